// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state type, BCD digit constants and a counter-width helper.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  // Number of bits needed to hold values 0..value-1; called with BIN_W+1
  // so the bit counter can hold BIN_W itself.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the shift so that the doubled value carries correctly into the next digit.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(ADD3_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] ADD3   = BCD_DIGIT_W'(3);

  // Wrap-around 4-bit add; a legal digit (0..9) never overflows here.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= THRESH) begin
      digit_o = digit_i + ADD3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// The packed BCD result is held between conversions so a downstream
// combinational BCD adder always sees a steady operand.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = clog2(BIN_W + 1);

  localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;
  localparam longint unsigned MAX_DEC = 64'd10 ** DIGITS;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Refuse to elaborate configurations that cannot represent every input.
  if (BIN_W < 1 || BIN_W > 16) begin : gBadBinW
    $error("bin_to_bcd_seq: BIN_W must be in 1..16");
  end
  if (MAX_DEC <= MAX_BIN) begin : gBadDigits
    $error("bin_to_bcd_seq: DIGITS too small, need 10**DIGITS > 2**BIN_W-1");
  end

  state_e             state_q, state_d;
  logic [SR_W-1:0]    shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcdOut_q, bcdOut_d;

  logic [BCD_W-1:0]   adjDigits;
  logic [SR_W-1:0]    adjReg;
  logic [SR_W-1:0]    shifted;

  // Correct every digit of the pre-shift register in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit_adj uAdj (
      .digit_i(shiftReg_q[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .digit_o(adjDigits[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign adjReg  = {adjDigits, shiftReg_q[BIN_W-1:0]};
  assign shifted = adjReg << 1;

  // State and datapath registers; reset clears everything, aborting any
  // conversion in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcdOut_q   <= '0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      bitCnt_q   <= bitCnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcdOut_q   <= bcdOut_d;
    end
  end

  // Next-state logic: accept start only in IDLE, then adjust-and-shift one
  // bit per cycle; the result is published on the last shift only.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcdOut_d   = bcdOut_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shiftReg_d = SR_W'(bin_in);
          bitCnt_d   = CNT_LOAD;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        shiftReg_d = shifted;
        bitCnt_d   = bitCnt_q - CNT_ONE;
        if (bitCnt_q == CNT_ONE) begin
          bcdOut_d = shifted[SR_W-1 -: BCD_W];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcdOut_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3). Expected BCD
// values come from decimal arithmetic (hundreds/tens/units).
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;
  localparam int TIMEOUT = 20;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  int vectors;
  int miscompares;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .bcd_out(bcd_out)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Decimal reference: split the value into hundreds, tens and units.
  function automatic logic [11:0] refBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit digitsValid(input logic [11:0] x);
    return (x[3:0] <= 4'd9) && (x[7:4] <= 4'd9) && (x[11:8] <= 4'd9);
  endfunction

  // Present start with value v for one edge; returns at the negedge after
  // the accepting edge, with bin_in scrambled.
  task automatic startConv(input logic [BIN_W-1:0] v);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
  endtask

  // Wait for done (bounded), counting cycles since acceptance and cycles
  // with busy high; bin_in keeps changing to prove it is not re-sampled.
  task automatic waitDone(output int cycles, output int busyCnt);
    cycles  = 0;
    busyCnt = 0;
    while (!done && cycles < TIMEOUT) begin
      if (busy) busyCnt++;
      @(negedge clk);
      bin_in = BIN_W'($urandom);
      cycles++;
    end
  endtask

  task automatic runConv(input logic [BIN_W-1:0] v, output int cycles,
                         output int busyCnt, output logic [11:0] result,
                         output logic doneNext);
    startConv(v);
    waitDone(cycles, busyCnt);
    result = bcd_out;
    @(negedge clk);
    doneNext = done;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd77;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      $display("[TB] FAIL reset: busy=%b done=%b bcd=%h, want 0 0 000", busy, done, bcd_out);
      miscompares++;
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      $display("[TB] FAIL reset_idle_busy: got %b want 0", busy);
      miscompares++;
    end
  endtask

  task automatic test_zero();
    int cycles, busyCnt;
    logic [11:0] res;
    logic dn;
    runConv(8'd0, cycles, busyCnt, res, dn);
    vectors++;
    if (cycles !== BIN_W || busyCnt !== BIN_W) begin
      $display("[TB] FAIL zero_latency: cycles=%0d busy=%0d want %0d", cycles, busyCnt, BIN_W);
      miscompares++;
    end
    vectors++;
    if (res !== 12'h000 || dn !== 1'b0) begin
      $display("[TB] FAIL zero_result: bcd=%h doneNext=%b want 000 0", res, dn);
      miscompares++;
    end
  endtask

  task automatic test_directed();
    logic [BIN_W-1:0] vals [3] = '{8'd255, 8'd9, 8'd100};
    int cycles, busyCnt;
    logic [11:0] res;
    logic dn;
    foreach (vals[i]) begin
      runConv(vals[i], cycles, busyCnt, res, dn);
      vectors++;
      if (res !== refBcd(int'(vals[i])) || cycles !== BIN_W || dn !== 1'b0) begin
        $display("[TB] FAIL directed_%0d: bcd=%h cycles=%0d doneNext=%b want %h %0d 0",
                 vals[i], res, cycles, dn, refBcd(int'(vals[i])), BIN_W);
        miscompares++;
      end
    end
  endtask

  task automatic test_sweep();
    int cycles, busyCnt;
    logic [11:0] res;
    logic dn;
    for (int v = 0; v < 256; v++) begin
      runConv(BIN_W'(v), cycles, busyCnt, res, dn);
      vectors++;
      if (res !== refBcd(v) || !digitsValid(res) || cycles !== BIN_W) begin
        $display("[TB] FAIL sweep_%0d: bcd=%h cycles=%0d want %h %0d", v, res, cycles, refBcd(v), BIN_W);
        miscompares++;
      end
    end
    for (int n = 0; n < 24; n++) begin
      int v;
      v = int'($urandom_range(255, 0));
      runConv(BIN_W'(v), cycles, busyCnt, res, dn);
      vectors++;
      if (res !== refBcd(v) || dn !== 1'b0) begin
        $display("[TB] FAIL random_%0d: bcd=%h doneNext=%b want %h 0", v, res, dn, refBcd(v));
        miscompares++;
      end
    end
  endtask

  task automatic test_ignore_busy();
    int cycles, extraDone;
    startConv(8'd73);
    cycles = 0;
    repeat (2) begin
      @(negedge clk);
      cycles++;
    end
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    cycles++;
    start = 1'b0;
    while (!done && cycles < TIMEOUT) begin
      @(negedge clk);
      cycles++;
    end
    vectors++;
    if (cycles !== BIN_W || bcd_out !== 12'h073) begin
      $display("[TB] FAIL ignore_busy: bcd=%h cycles=%0d want 073 %0d", bcd_out, cycles, BIN_W);
      miscompares++;
    end
    extraDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extraDone++;
    end
    vectors++;
    if (extraDone !== 0) begin
      $display("[TB] FAIL ignore_busy_extra: %0d busy/done cycles want 0", extraDone);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    int cycles, busyCnt, holdBad;
    startConv(8'd99);
    waitDone(cycles, busyCnt);
    vectors++;
    if (bcd_out !== 12'h099 || cycles !== BIN_W) begin
      $display("[TB] FAIL b2b_first: bcd=%h cycles=%0d want 099 %0d", bcd_out, cycles, BIN_W);
      miscompares++;
    end
    start  = 1'b1;
    bin_in = 8'd42;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("[TB] FAIL b2b_accept: busy=%b done=%b want 1 0", busy, done);
      miscompares++;
    end
    holdBad = 0;
    cycles  = 0;
    while (!done && cycles < TIMEOUT) begin
      if (bcd_out !== 12'h099) holdBad++;
      @(negedge clk);
      bin_in = BIN_W'($urandom);
      cycles++;
    end
    vectors++;
    if (holdBad !== 0 || cycles !== BIN_W || bcd_out !== 12'h042) begin
      $display("[TB] FAIL b2b_second: holdBad=%0d cycles=%0d bcd=%h want 0 %0d 042",
               holdBad, cycles, bcd_out, BIN_W);
      miscompares++;
    end
  endtask

  task automatic test_abort();
    int cycles, busyCnt, lateDone;
    logic [11:0] res;
    logic dn;
    startConv(8'd150);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 12'h000) begin
      $display("[TB] FAIL abort_state: busy=%b done=%b bcd=%h want 0 0 000", busy, done, bcd_out);
      miscompares++;
    end
    lateDone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) lateDone++;
    end
    vectors++;
    if (lateDone !== 0) begin
      $display("[TB] FAIL abort_no_done: %0d done pulses want 0", lateDone);
      miscompares++;
    end
    runConv(8'd150, cycles, busyCnt, res, dn);
    vectors++;
    if (res !== 12'h150 || cycles !== BIN_W) begin
      $display("[TB] FAIL abort_restart: bcd=%h cycles=%0d want 150 %0d", res, cycles, BIN_W);
      miscompares++;
    end
  endtask

  // Scenario sequence, ending with the one-line summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    test_reset();
    test_zero();
    test_directed();
    test_sweep();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
